// File: rtl/imem_loader.sv
// Streams a length-prefixed program into the core's instruction memory over a
// byte valid/ready handshake, holding the core in reset until the load completes.
module imem_loader #(
    parameter int PC_SIZE = 10,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               rw,
    output logic [31:0]        instruction_out,
    output logic [PC_SIZE-1:0] PC_write,
    output logic               reset_IF_memory,
    output logic               core_reset,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    // Largest accepted program: one word per instruction address.
    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(1) << PC_SIZE;

    state_t           state_reg;
    logic [7:0]       len_lo_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [1:0]       byte_idx_reg;
    logic [23:0]      word_reg;

    logic             xfer;
    logic [15:0]      len_next;
    logic [CNT_W:0]   len_ext;

    assign xfer     = in_valid & in_ready;
    assign len_next = {in_data, len_lo_reg};
    assign len_ext  = (CNT_W + 1)'(len_next);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            len_lo_reg      <= '0;
            remaining_reg   <= '0;
            byte_idx_reg    <= '0;
            word_reg        <= '0;
            in_ready        <= 1'b0;
            rw              <= 1'b0;
            instruction_out <= '0;
            PC_write        <= '0;
            reset_IF_memory <= 1'b0;
            core_reset      <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one state.
            rw              <= 1'b0;
            reset_IF_memory <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_reg       <= S_CLR;
                        done            <= 1'b0;
                        err             <= 1'b0;
                        busy            <= 1'b1;
                        core_reset      <= 1'b1;
                        remaining_reg   <= '0;
                        byte_idx_reg    <= '0;
                        PC_write        <= '0;
                        reset_IF_memory <= 1'b1;
                    end
                end
                S_CLR: begin
                    state_reg <= S_LEN0;
                    in_ready  <= 1'b1;
                end
                S_LEN0: begin
                    if (xfer) begin
                        len_lo_reg <= in_data;
                        state_reg  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        remaining_reg <= CNT_W'(len_next);
                        if (len_next == 16'd0) begin
                            state_reg  <= S_DONE;
                            in_ready   <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else if (len_ext > MAX_WORDS) begin
                            state_reg <= S_ERR;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            err       <= 1'b1;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            instruction_out <= {in_data, word_reg};
                            in_ready        <= 1'b0;
                            rw              <= 1'b1;
                            state_reg       <= S_WRITE;
                        end else begin
                            word_reg[8*byte_idx_reg +: 8] <= in_data;
                        end
                    end
                end
                S_WRITE: begin
                    // Wrap of PC_write after a full-memory load is harmless: the load ends here.
                    PC_write      <= PC_write + 1'b1;
                    remaining_reg <= remaining_reg - 1'b1;
                    if (remaining_reg == CNT_W'(1)) begin
                        state_reg  <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        core_reset <= 1'b0;
                    end else begin
                        state_reg <= S_DATA;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
